// File: rtl/fifo_rd_drain_ctrl.sv
// Read-domain drain controller: pops a first-word-fall-through FIFO one word at a
// time and hands each word to a busy-flagged transmitter, then idles for a gap.
module fifo_rd_drain_ctrl #(
  parameter int Data_Width  = 8,
  parameter int GAP_CYCLES  = 2,
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Enable,
  input  logic                  FIFO_Empty,
  input  logic [Data_Width-1:0] FIFO_Data,
  output logic                  FIFO_R_INC,
  input  logic                  TX_Busy,
  output logic [Data_Width-1:0] TX_Data,
  output logic                  TX_Data_Valid,
  output logic [CNT_WIDTH-1:0]  Words_Sent,
  output logic                  Ack_Err,
  output logic                  Idle
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LAUNCH,
    S_WAIT_RISE,
    S_WAIT_FALL,
    S_GAP
  } state_t;

  localparam int TMAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  // With no gap configured, the end of a word returns straight to IDLE.
  localparam state_t POST_WORD = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [TW-1:0]         r_timer;
  logic [TW-1:0]         w_timer_nxt;
  logic                  r_pop;
  logic                  r_valid;
  logic                  r_idle;
  logic                  r_ack_err;
  logic [Data_Width-1:0] r_tx_data;
  logic [CNT_WIDTH-1:0]  r_words;
  logic                  w_pop_nxt;
  logic                  w_valid_nxt;
  logic                  w_idle_nxt;
  logic                  w_load;
  logic                  w_cnt_inc;
  logic                  w_ack_set;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:      if (Enable && !FIFO_Empty && !TX_Busy) w_state_nxt = S_FETCH;
      S_FETCH:     w_state_nxt = S_LAUNCH;
      S_LAUNCH:    w_state_nxt = S_WAIT_RISE;
      S_WAIT_RISE: begin
        if (TX_Busy) begin
          w_state_nxt = S_WAIT_FALL;
        end else if (r_timer == ACK_LAST) begin
          w_state_nxt = POST_WORD;
        end
      end
      S_WAIT_FALL: if (!TX_Busy) w_state_nxt = POST_WORD;
      S_GAP:       if (r_timer == GAP_LAST) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so each strobe
  // appears in the cycle the FSM occupies the matching state.
  always_comb begin
    w_pop_nxt   = (w_state_nxt == S_FETCH);
    w_valid_nxt = (w_state_nxt == S_LAUNCH);
    w_idle_nxt  = (w_state_nxt == S_IDLE);
    w_load      = (r_state == S_FETCH);
    w_cnt_inc   = (r_state == S_WAIT_RISE) && TX_Busy;
    w_ack_set   = (r_state == S_WAIT_RISE) && !TX_Busy && (r_timer == ACK_LAST);
    w_timer_nxt = r_timer;
    if (w_state_nxt != r_state) begin
      w_timer_nxt = '0;
    end else if ((r_state == S_WAIT_RISE) || (r_state == S_GAP)) begin
      w_timer_nxt = r_timer + TW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_timer   <= '0;
      r_pop     <= 1'b0;
      r_valid   <= 1'b0;
      r_idle    <= 1'b1;
      r_ack_err <= 1'b0;
      r_tx_data <= '0;
      r_words   <= '0;
    end else begin
      r_timer <= w_timer_nxt;
      r_pop   <= w_pop_nxt;
      r_valid <= w_valid_nxt;
      r_idle  <= w_idle_nxt;
      if (w_load) begin
        r_tx_data <= FIFO_Data;
      end
      if (w_cnt_inc) begin
        r_words <= r_words + CNT_WIDTH'(1);
      end
      if (w_ack_set) begin
        r_ack_err <= 1'b1;
      end
    end
  end

  assign FIFO_R_INC    = r_pop;
  assign TX_Data       = r_tx_data;
  assign TX_Data_Valid = r_valid;
  assign Words_Sent    = r_words;
  assign Ack_Err       = r_ack_err;
  assign Idle          = r_idle;

endmodule
